// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : Oversampled UART receiver. Recovers start / data (LSB first)
//                / optional even parity / stop frames from an asynchronous
//                line, pushes good words into an RX FIFO and flags framing,
//                parity and overrun errors as single-cycle pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter logic Parity      = 1'b0,
  parameter int   StopBit     = 1,
  parameter int   DataLength  = 8,
  parameter int   OverSample  = 8,
  parameter logic FlowControl = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_rx,
  output logic                  o_rts,
  output logic [DataLength-1:0] o_rx_fifo_data,
  output logic                  o_rx_fifo_write_en,
  input  logic                  i_rx_fifo_full,
  output logic                  o_frame_err,
  output logic                  o_parity_err,
  output logic                  o_overrun_err
);

  localparam int CW = $clog2(OverSample);
  localparam int BW = ($clog2(DataLength) > 0) ? $clog2(DataLength) : 1;
  localparam logic [CW-1:0] HALF_LOAD = CW'(OverSample / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(OverSample - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DataLength - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_DONE   = 3'd5,
    S_BREAK  = 3'd6
  } state_t;

  state_t                  state, state_next;
  logic [1:0]              sync;
  logic                    rx_s;
  logic [CW-1:0]           clk_counter;
  logic [BW-1:0]           bit_counter;
  logic [DataLength-1:0]   shift_reg;
  logic [DataLength-1:0]   shift_next;
  logic                    par_bit;
  logic                    stop_bit;
  logic                    stop_ok;
  logic                    tick;

  assign rx_s = sync[1];
  assign tick = (clk_counter == '0);
  assign o_rx_fifo_data = shift_reg;

  // Only a single stop bit is supported; any other setting rejects every frame.
  generate
    if (StopBit == 1) begin : g_one_stop
      assign stop_ok = stop_bit;
    end else begin : g_unsupported_stop
      assign stop_ok = 1'b0;
    end
  endgenerate

  // Two-flop synchronizer on the raw line; idles high so reset looks like an idle line.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sync <= 2'b11;
    else          sync <= {sync[0], i_rx};
  end

  // Right shift with the newest bit entering at the MSB so LSB-first data lands in place.
  always_comb begin
    shift_next = shift_reg >> 1;
    shift_next[DataLength-1] = rx_s;
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state and DONE-cycle output decode; exactly one outcome per completed frame.
  always_comb begin
    state_next         = state;
    o_rx_fifo_write_en = 1'b0;
    o_frame_err        = 1'b0;
    o_parity_err       = 1'b0;
    o_overrun_err      = 1'b0;
    case (state)
      S_IDLE:   if (!rx_s) state_next = S_START;
      S_START:  if (tick) state_next = rx_s ? S_IDLE : S_DATA;
      S_DATA:   if (tick && bit_counter == LAST_BIT) state_next = Parity ? S_PARITY : S_STOP;
      S_PARITY: if (tick) state_next = S_STOP;
      S_STOP:   if (tick) state_next = S_DONE;
      S_DONE: begin
        state_next = S_IDLE;
        if (!stop_ok) begin
          o_frame_err = 1'b1;
          state_next  = S_BREAK;
        end else if (Parity && (^{shift_reg, par_bit})) begin
          o_parity_err = 1'b1;
        end else if (i_rx_fifo_full) begin
          o_overrun_err = 1'b1;
        end else begin
          o_rx_fifo_write_en = 1'b1;
        end
      end
      S_BREAK:  if (rx_s) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Bit-timing counters and the sampled data / parity / stop bits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clk_counter <= '0;
      bit_counter <= '0;
      shift_reg   <= '0;
      par_bit     <= 1'b0;
      stop_bit    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          clk_counter <= rx_s ? '0 : HALF_LOAD;
          bit_counter <= '0;
        end
        S_START: begin
          if (tick) begin
            clk_counter <= FULL_LOAD;
            bit_counter <= '0;
          end else begin
            clk_counter <= clk_counter - 1'b1;
          end
        end
        S_DATA: begin
          if (tick) begin
            shift_reg   <= shift_next;
            clk_counter <= FULL_LOAD;
            if (bit_counter != LAST_BIT) bit_counter <= bit_counter + 1'b1;
          end else begin
            clk_counter <= clk_counter - 1'b1;
          end
        end
        S_PARITY: begin
          if (tick) begin
            par_bit     <= rx_s;
            clk_counter <= FULL_LOAD;
          end else begin
            clk_counter <= clk_counter - 1'b1;
          end
        end
        S_STOP: begin
          if (tick) begin
            stop_bit    <= rx_s;
            clk_counter <= FULL_LOAD;
          end else begin
            clk_counter <= clk_counter - 1'b1;
          end
        end
        default: begin
          clk_counter <= '0;
          bit_counter <= '0;
        end
      endcase
    end
  end

  generate
    if (FlowControl) begin : g_rts_flow
      logic rts_q;
      // Ready-to-receive follows FIFO space one cycle later.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rts_q <= 1'b0;
        else          rts_q <= ~i_rx_fifo_full;
      end
      assign o_rts = rts_q;
    end else begin : g_rts_const
      assign o_rts = 1'b1;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Directed plus randomized bench for uart_rx. Port A has no
//                parity and flow control on; port B has even parity and no
//                flow control. Expected outcomes and their cycle of arrival
//                come from frame-level rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int N = 8;
  localparam int D = 8;

  typedef struct {
    int         port;
    int         cyc;
    int         kind;   // 0 write, 1 frame error, 2 parity error, 3 overrun
    logic [D-1:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_a = 1'b1, rx_b = 1'b1;
  logic full_a = 1'b0, full_b = 1'b0;
  logic rts_a, rts_b;
  logic [D-1:0] data_a, data_b;
  logic we_a, fe_a, pe_a, oe_a;
  logic we_b, fe_b, pe_b, oe_b;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  ev_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.Parity(1'b0), .StopBit(1), .DataLength(D), .OverSample(N), .FlowControl(1'b1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx_a), .o_rts(rts_a),
    .o_rx_fifo_data(data_a), .o_rx_fifo_write_en(we_a), .i_rx_fifo_full(full_a),
    .o_frame_err(fe_a), .o_parity_err(pe_a), .o_overrun_err(oe_a)
  );

  uart_rx #(.Parity(1'b1), .StopBit(1), .DataLength(D), .OverSample(N), .FlowControl(1'b0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx_b), .o_rts(rts_b),
    .o_rx_fifo_data(data_b), .o_rx_fifo_write_en(we_b), .i_rx_fifo_full(full_b),
    .o_frame_err(fe_b), .o_parity_err(pe_b), .o_overrun_err(oe_b)
  );

  // Compare every observed pulse against the next predicted event; flag predictions that expire.
  task automatic check_port(input int port, input logic we, input logic fe, input logic pe,
                            input logic oe, input logic [D-1:0] d);
    ev_t e;
    int  kind;
    if (exp_q.size() > 0 && exp_q[0].port == port) begin
      checks++;
      assert (exp_q[0].cyc >= cyc) else begin
        errors++;
        $error("FAIL missed_event port=%0d observed none, expected kind=%0d at cycle %0d",
               port, exp_q[0].kind, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
    end
    if (we | fe | pe | oe) begin
      kind = we ? 0 : fe ? 1 : pe ? 2 : 3;
      checks++;
      assert ($countones({we, fe, pe, oe}) === 1) else begin
        errors++;
        $error("FAIL exclusive_flags port=%0d observed we/fe/pe/oe=%b%b%b%b, expected one-hot",
               port, we, fe, pe, oe);
      end
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_event port=%0d observed kind=%0d at cycle %0d, expected none",
               port, kind, cyc);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        assert (port === e.port && kind === e.kind && cyc === e.cyc) else begin
          errors++;
          $error("FAIL event port=%0d observed kind=%0d cyc=%0d, expected port=%0d kind=%0d cyc=%0d",
                 port, kind, cyc, e.port, e.kind, e.cyc);
        end
        if (e.kind == 0) begin
          checks++;
          assert (d === e.data) else begin
            errors++;
            $error("FAIL rx_data port=%0d observed %h, expected %h", port, d, e.data);
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    check_port(0, we_a, fe_a, pe_a, oe_a, data_a);
    check_port(1, we_b, fe_b, pe_b, oe_b, data_b);
  end

  task automatic drive_bit(input int port, input logic v);
    if (port == 0) rx_a = v;
    else           rx_b = v;
    repeat (N) @(negedge clk);
  endtask

  // Called on a negedge; returns on a negedge exactly one frame length later.
  task automatic send_frame(input int port, input logic [D-1:0] d, input logic pbit,
                            input logic stopv);
    ev_t e;
    int  p;
    p = (port == 1) ? 1 : 0;
    e.port = port;
    e.data = d;
    e.cyc  = cyc + 2 + N / 2 + N * (D + p + 1) + 1;
    if (!stopv)                       e.kind = 1;
    else if (p == 1 && ((^d) ^ pbit)) e.kind = 2;
    else if ((port == 0) ? full_a : full_b) e.kind = 3;
    else                              e.kind = 0;
    exp_q.push_back(e);
    drive_bit(port, 1'b0);
    for (int i = 0; i < D; i++) drive_bit(port, d[i]);
    if (p == 1) drive_bit(port, pbit);
    drive_bit(port, stopv);
  endtask

  task automatic check_val(input string tag, input logic [D-1:0] obs, input logic [D-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h, expected %h", tag, obs, expv);
    end
  endtask

  initial begin
    logic [D-1:0] d;
    logic [7:0]   c3;

    // Reset state.
    repeat (3) @(negedge clk);
    check_val("reset_rts_a", {7'd0, rts_a}, 8'h00);
    check_val("reset_data_a", data_a, 8'h00);
    check_val("reset_flags_a", {4'd0, we_a, fe_a, pe_a, oe_a}, 8'h00);
    check_val("reset_data_b", data_b, 8'h00);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_val("rts_a_ready", {7'd0, rts_a}, 8'h01);
    check_val("rts_b_const", {7'd0, rts_b}, 8'h01);

    // Good frame, then three back-to-back frames with no idle gap.
    send_frame(0, 8'hA5, 1'b0, 1'b1);
    send_frame(0, 8'h00, 1'b0, 1'b1);
    send_frame(0, 8'hFF, 1'b0, 1'b1);
    send_frame(0, 8'h3C, 1'b0, 1'b1);
    repeat (2 * N) @(negedge clk);

    // Glitch shorter than half a bit.
    rx_a = 1'b0;
    repeat (2) @(negedge clk);
    rx_a = 1'b1;
    repeat (3 * N) @(negedge clk);

    // Framing error followed by a long break, then a good frame.
    send_frame(0, 8'h55, 1'b0, 1'b0);
    repeat (200) @(negedge clk);
    rx_a = 1'b1;
    repeat (2 * N) @(negedge clk);
    send_frame(0, 8'h96, 1'b0, 1'b1);
    repeat (2 * N) @(negedge clk);

    // Overrun and RTS.
    full_a = 1'b1;
    @(negedge clk);
    check_val("rts_full", {7'd0, rts_a}, 8'h00);
    send_frame(0, 8'h5A, 1'b0, 1'b1);
    repeat (N) @(negedge clk);
    full_a = 1'b0;
    @(negedge clk);
    check_val("rts_free", {7'd0, rts_a}, 8'h01);
    repeat (N) @(negedge clk);

    // Parity port: correct and incorrect parity bit.
    send_frame(1, 8'h01, 1'b1, 1'b1);
    send_frame(1, 8'h01, 1'b0, 1'b1);
    repeat (2 * N) @(negedge clk);

    // Randomized frames on both ports.
    for (int i = 0; i < 8; i++) begin
      d = D'($urandom);
      send_frame(0, d, 1'b0, 1'b1);
    end
    repeat (2 * N) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      d = D'($urandom);
      full_b = ($urandom_range(0, 3) == 0);
      send_frame(1, d, (^d) ^ ($urandom_range(0, 2) == 0), 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    full_b = 1'b0;
    repeat (2 * N) @(negedge clk);

    // Reset in the middle of data bit 4 of 0xC3.
    c3 = 8'hC3;
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, c3[i]);
    rx_a = c3[4];
    repeat (N / 2) @(negedge clk);
    rst_n = 1'b0;
    rx_a  = 1'b1;
    #1;
    check_val("midreset_data", data_a, 8'h00);
    check_val("midreset_flags", {4'd0, we_a, fe_a, pe_a, oe_a}, 8'h00);
    check_val("midreset_rts", {7'd0, rts_a}, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * N) @(negedge clk);
    send_frame(0, 8'h81, 1'b0, 1'b1);
    repeat (4 * N) @(negedge clk);

    checks++;
    assert (exp_q.size() === 0) else begin
      errors++;
      $error("FAIL pending_events observed %0d outstanding, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
